// File: rtl/mlp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mlp_pkg
// Description : Shared types and helpers for the streaming MLP layer: FSM
//               state encoding, output saturation bounds and the
//               shift / activate / clip post-process.
// Revision    : 1.0 - initial release
// ============================================================================
package mlp_pkg;

    // Layer sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_POST  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Working width for post-processing; accumulators up to this width are supported
    localparam int MLP_WIDE_W = 128;
    typedef logic signed [MLP_WIDE_W-1:0] wide_t;

    typedef struct packed {
        logic  clipped;
        wide_t value;
    } post_t;

    // Largest value representable in a signed out_w-bit result
    function automatic wide_t sat_max(input int out_w);
        return (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
    endfunction

    // Smallest value representable in a signed out_w-bit result
    function automatic wide_t sat_min(input int out_w);
        return -(wide_t'(1) <<< (out_w - 1));
    endfunction

    // Arithmetic rescale, optional ReLU, then clip into the signed output range
    function automatic post_t post_process(input wide_t acc, input int frac,
                                           input logic relu, input int out_w);
        wide_t s;
        post_t r;
        s = acc >>> frac;
        if (relu && (s < 0)) begin
            s = '0;
        end
        r.clipped = 1'b0;
        r.value   = s;
        if (s > sat_max(out_w)) begin
            r.clipped = 1'b1;
            r.value   = sat_max(out_w);
        end else if (s < sat_min(out_w)) begin
            r.clipped = 1'b1;
            r.value   = sat_min(out_w);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mlp_layer_stream_weight_bank.sv
`default_nettype none
// ============================================================================
// Module      : mlp_weight_bank
// Description : One synchronous-read weight RAM per neuron. All lanes share
//               the read address; writes are decoded by row and range-checked
//               so out-of-range row/column indices are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_weight_bank #(
    parameter int N_INPUTS  = 3,
    parameter int N_NEURONS = 4,
    parameter int WGT_WIDTH = 16,
    parameter int ROW_W     = 2,
    parameter int COL_W     = 2
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [ROW_W-1:0]               wr_row,
    input  logic [COL_W-1:0]               wr_col,
    input  logic [WGT_WIDTH-1:0]           wr_data,
    input  logic [COL_W-1:0]               rd_addr,
    output logic [N_NEURONS*WGT_WIDTH-1:0] rd_data
);

    localparam logic [ROW_W:0] c_rows = N_NEURONS[ROW_W:0];
    localparam logic [COL_W:0] c_cols = N_INPUTS[COL_W:0];

    logic w_wr_ok;

    assign w_wr_ok = wr_en && ({1'b0, wr_row} < c_rows) && ({1'b0, wr_col} < c_cols);

    for (genvar j = 0; j < N_NEURONS; j++) begin : g_lane
        logic [WGT_WIDTH-1:0] mem [N_INPUTS];
        logic [WGT_WIDTH-1:0] r_rd;

        // Row-decoded write and one-cycle registered read of this neuron's weights
        always_ff @(posedge clk) begin
            if (w_wr_ok && (wr_row == ROW_W'(j))) begin
                mem[wr_col] <= wr_data;
            end
            r_rd <= mem[rd_addr];
        end

        assign rd_data[j*WGT_WIDTH +: WGT_WIDTH] = r_rd;
    end

endmodule
`default_nettype wire

// File: rtl/mlp_layer_stream.sv
`default_nettype none
// ============================================================================
// Module      : mlp_layer_stream
// Description : Fully-connected MLP layer with N_NEURONS parallel MAC lanes,
//               valid/ready input element stream and output vector stream,
//               rescale, optional ReLU and saturation to OUT_WIDTH.
//               Optional macro MLP_LAYER_SAT_FLAGS_EN adds per-neuron
//               saturation flags registered alongside out_data.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_layer_stream
    import mlp_pkg::*;
#(
    parameter int N_INPUTS  = 3,
    parameter int N_NEURONS = 4,
    parameter int IN_WIDTH  = 16,
    parameter int WGT_WIDTH = 16,
    parameter int MAC_WIDTH = 64,
    parameter int OUT_WIDTH = 16,
    parameter int FRAC_BITS = 0,
    parameter int ACT_RELU  = 1,
    localparam int ROW_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    localparam int COL_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [ROW_W-1:0]               wr_row,
    input  logic [COL_W-1:0]               wr_col,
    input  logic [WGT_WIDTH-1:0]           wr_weight,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IN_WIDTH-1:0]            in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_NEURONS*OUT_WIDTH-1:0] out_data,
    output logic                           busy
`ifdef MLP_LAYER_SAT_FLAGS_EN
    ,
    output logic [N_NEURONS-1:0]           sat_flags
`endif
);

    localparam logic [COL_W-1:0] c_last_k = COL_W'(N_INPUTS - 1);

    state_t                           r_state;
    state_t                           w_state_next;
    logic [COL_W-1:0]                 r_k;
    logic                             r_mac_en;
    logic                             r_first;
    logic signed [IN_WIDTH-1:0]       r_data;
    logic [N_NEURONS*WGT_WIDTH-1:0]   w_rd_data;
    logic [N_NEURONS*OUT_WIDTH-1:0]   w_out_next;
    logic [N_NEURONS-1:0]             w_clip_next;
    logic                             w_hs;
    logic                             w_last;
    logic                             w_wr_ok;
    logic                             w_capture;

    // Weight writes win over input in IDLE; ACCUM always accepts elements
    assign in_ready  = ((r_state == ST_IDLE) && !wr_en) || (r_state == ST_ACCUM);
    assign w_hs      = in_valid && in_ready;
    assign w_last    = (r_k == c_last_k);
    assign w_wr_ok   = wr_en && (r_state == ST_IDLE);
    // POST waits until the in-flight final MAC has landed before capturing
    assign w_capture = (r_state == ST_POST) && !r_mac_en;
    assign busy      = (r_state != ST_IDLE);

    mlp_weight_bank #(
        .N_INPUTS  (N_INPUTS),
        .N_NEURONS (N_NEURONS),
        .WGT_WIDTH (WGT_WIDTH),
        .ROW_W     (ROW_W),
        .COL_W     (COL_W)
    ) u_weight_bank (
        .clk     (clk),
        .wr_en   (w_wr_ok),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_weight),
        .rd_addr (r_k),
        .rd_data (w_rd_data)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_hs) w_state_next = w_last ? ST_POST : ST_ACCUM;
            ST_ACCUM: if (w_hs && w_last) w_state_next = ST_POST;
            ST_POST:  if (!r_mac_en) w_state_next = ST_OUT;
            ST_OUT:   if (out_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Element counter plus data/flags registered to line up with the weight read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k      <= '0;
            r_mac_en <= 1'b0;
            r_first  <= 1'b0;
            r_data   <= '0;
        end else begin
            r_mac_en <= w_hs;
            if (w_hs) begin
                r_k     <= w_last ? '0 : r_k + 1'b1;
                r_first <= (r_k == '0);
                r_data  <= in_data;
            end
        end
    end

    for (genvar j = 0; j < N_NEURONS; j++) begin : g_lane
        logic signed [IN_WIDTH+WGT_WIDTH-1:0] w_prod;
        logic signed [MAC_WIDTH-1:0]          r_acc;
        post_t                                w_post;

        assign w_prod = r_data * $signed(w_rd_data[j*WGT_WIDTH +: WGT_WIDTH]);

        // Accumulate; the first element of a vector restarts the sum, overflow wraps
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_acc <= '0;
            end else if (r_mac_en) begin
                r_acc <= r_first ? MAC_WIDTH'(w_prod) : r_acc + MAC_WIDTH'(w_prod);
            end
        end

        assign w_post = post_process(wide_t'(r_acc), FRAC_BITS, (ACT_RELU != 0), OUT_WIDTH);
        assign w_out_next[j*OUT_WIDTH +: OUT_WIDTH] = w_post.value[OUT_WIDTH-1:0];
        assign w_clip_next[j] = w_post.clipped;
    end

    // Output vector register and valid flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (w_capture) begin
            out_valid <= 1'b1;
            out_data  <= w_out_next;
        end else if ((r_state == ST_OUT) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MLP_LAYER_SAT_FLAGS_EN
    // Saturation flags captured and held with out_data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flags <= '0;
        end else if (w_capture) begin
            sat_flags <= w_clip_next;
        end
    end
`else
    logic w_clip_unused;
    assign w_clip_unused = ^w_clip_next;
`endif

endmodule
`default_nettype wire
